multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/mc_alu_decoder.sv | 49 ++++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
//------------------------------------------------------------------------------
// Module   : mc_pkg
// Purpose  : Shared state encodings, opcode/funct values and datapath select
//            codes for the multicycle controller. ADDI states exist only when
//            MC_ADDI_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
`endif
    } state_t;

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [1:0] c_srcb_regb  = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_alu_decoder.sv
//------------------------------------------------------------------------------
// Module   : mc_alu_decoder
// Purpose  : Maps the FSM's aluop request plus funct onto the ALU control code,
//            zero-extended to ALUCTRL_W bits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_alu_decoder
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [1:0]           aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control
);

    logic [2:0] w_code;

    always_comb begin
        w_code = c_alu_add;
        case (aluop)
            c_aluop_sub: w_code = c_alu_sub;
            c_aluop_funct: begin
                case (funct)
                    c_fn_add: w_code = c_alu_add;
                    c_fn_sub: w_code = c_alu_sub;
                    c_fn_and: w_code = c_alu_and;
                    c_fn_or:  w_code = c_alu_or;
                    c_fn_slt: w_code = c_alu_slt;
                    default:  w_code = c_alu_add;
                endcase
            end
            default: w_code = c_alu_add;
        endcase
    end

    generate
        if (ALUCTRL_W > 3) begin : g_pad
            assign alu_control = {{(ALUCTRL_W-3){1'b0}}, w_code};
        end else begin : g_nopad
            assign alu_control = w_code;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
//------------------------------------------------------------------------------
// Module   : multicycle_controller
// Purpose  : Multicycle MIPS-style control FSM with optional memory stalling.
//            Define MC_ADDI_EN to add the ADDIEX/ADDIWB immediate-add path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W     = 3,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 memto_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic                 pc_en,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal,
    output logic [3:0]           state
);

    state_t     state_q, state_d;
    logic       w_mem_ready;
    logic       w_pc_write, w_branch, w_illegal;
    logic       w_ir_write, w_mem_write, w_reg_write;
    logic [1:0] w_aluop;

    assign w_mem_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    c_op_lw, c_op_sw: state_d = S_MEMADR;
                    c_op_rtype:       state_d = S_EXECUTE;
                    c_op_beq:         state_d = S_BRANCH;
                    c_op_j:           state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    c_op_addi:        state_d = S_ADDIEX;
`endif
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == c_op_sw) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = w_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = w_mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        iord        = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        reg_dst     = 1'b0;
        memto_reg   = 1'b0;
        w_reg_write = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = c_srcb_regb;
        pc_src      = c_pcsrc_alu;
        w_aluop     = c_aluop_add;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = c_srcb_four;
                w_ir_write = w_mem_ready;
                w_pc_write = w_mem_ready;
            end
            S_DECODE: begin
                alu_src_b = c_srcb_immsh;
                case (opcode)
                    c_op_lw, c_op_sw, c_op_rtype, c_op_beq, c_op_j: w_illegal = 1'b0;
`ifdef MC_ADDI_EN
                    c_op_addi: w_illegal = 1'b0;
`endif
                    default: w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_srcb_imm;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memto_reg   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                w_aluop   = c_aluop_funct;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                w_aluop   = c_aluop_sub;
                pc_src    = c_pcsrc_aluout;
                w_branch  = 1'b1;
            end
            S_JUMP: begin
                pc_src     = c_pcsrc_jump;
                w_pc_write = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = c_srcb_imm;
            end
            S_ADDIWB: w_reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    // Write strobes are forced low while reset is held, whatever state is showing.
    assign mem_write = w_mem_write & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign ir_write  = w_ir_write & ~reset;
    assign illegal   = w_illegal & ~reset;
    assign pc_en     = (w_pc_write | (w_branch & zero)) & ~reset;
    assign state     = state_q;

    mc_alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .aluop       (w_aluop),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_controller
// Purpose  : Scenario-driven bench for multicycle_controller; a second instance
//            with ALUCTRL_W=5 shares the stimulus. Honours MC_ADDI_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = c_op_lw;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a, pc_en, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    logic       d2_iord, d2_mem_write, d2_ir_write, d2_reg_dst, d2_memto_reg, d2_reg_write;
    logic       d2_alu_src_a, d2_pc_en, d2_illegal;
    logic [1:0] d2_alu_src_b, d2_pc_src;
    logic [4:0] d2_alu_control;
    logic [3:0] d2_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a, pc_en;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluc;
        logic       illegal;
    } out_t;

    typedef struct packed {
        out_t e;
        out_t m;
    } ent_t;

    ent_t sb[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .pc_en(pc_en), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .illegal(illegal), .state(state)
    );

    multicycle_controller #(.ALUCTRL_W(5)) dut_w5 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(d2_iord), .mem_write(d2_mem_write),
        .ir_write(d2_ir_write), .reg_dst(d2_reg_dst), .memto_reg(d2_memto_reg),
        .reg_write(d2_reg_write), .alu_src_a(d2_alu_src_a), .pc_en(d2_pc_en),
        .alu_src_b(d2_alu_src_b), .pc_src(d2_pc_src), .alu_control(d2_alu_control),
        .illegal(d2_illegal), .state(d2_state)
    );

    function automatic out_t obs();
        out_t o;
        o.st = state; o.iord = iord; o.mem_write = mem_write; o.ir_write = ir_write;
        o.reg_dst = reg_dst; o.memto_reg = memto_reg; o.reg_write = reg_write;
        o.alu_src_a = alu_src_a; o.pc_en = pc_en; o.srcb = alu_src_b; o.pcsrc = pc_src;
        o.aluc = alu_control; o.illegal = illegal;
        return o;
    endfunction

    function automatic logic [2:0] funct_code(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for a given state and cycle inputs; alu_control is only
    // checked in states where the ALU operation is defined.
    function automatic ent_t expect_for(input logic [3:0] st, input logic rdy, input logic rst);
        ent_t r;
        logic legal;
        r.e = '0;
        r.m = '1;
        r.e.st = st;
        legal = (opcode == 6'b100011) || (opcode == 6'b101011) || (opcode == 6'b000000) ||
                (opcode == 6'b000100) || (opcode == 6'b000010);
`ifdef MC_ADDI_EN
        legal = legal || (opcode == 6'b001000);
`endif
        case (st)
            4'd0: begin r.e.srcb = 2'b01; r.e.aluc = 3'b010; r.e.ir_write = rdy; r.e.pc_en = rdy; end
            4'd1: begin r.e.srcb = 2'b11; r.e.aluc = 3'b010; r.e.illegal = !legal; end
            4'd2: begin r.e.alu_src_a = 1'b1; r.e.srcb = 2'b10; r.e.aluc = 3'b010; end
            4'd3: begin r.e.iord = 1'b1; r.m.aluc = '0; end
            4'd4: begin r.e.memto_reg = 1'b1; r.e.reg_write = 1'b1; r.m.aluc = '0; end
            4'd5: begin r.e.iord = 1'b1; r.e.mem_write = 1'b1; r.m.aluc = '0; end
            4'd6: begin r.e.alu_src_a = 1'b1; r.e.aluc = funct_code(funct); end
            4'd7: begin r.e.reg_dst = 1'b1; r.e.reg_write = 1'b1; r.m.aluc = '0; end
            4'd8: begin r.e.alu_src_a = 1'b1; r.e.aluc = 3'b110; r.e.pcsrc = 2'b01; r.e.pc_en = zero; end
            4'd9: begin r.e.pcsrc = 2'b10; r.e.pc_en = 1'b1; r.m.aluc = '0; end
            4'd10: begin r.e.alu_src_a = 1'b1; r.e.srcb = 2'b10; r.e.aluc = 3'b010; end
            4'd11: begin r.e.reg_write = 1'b1; r.m.aluc = '0; end
            default: r.m.aluc = '0;
        endcase
        if (rst) begin
            r.e.mem_write = 1'b0; r.e.reg_write = 1'b0; r.e.ir_write = 1'b0;
            r.e.pc_en = 1'b0; r.e.illegal = 1'b0;
        end
        return r;
    endfunction

    task automatic drive(input logic [3:0] st, input logic rdy, input logic rst);
        mem_ready = rdy;
        reset = rst;
        sb.push_back(expect_for(st, rdy, rst));
    endtask

    task automatic test_reset();
        logic [3:0] seq [3];
        logic       rdy [3];
        logic       rst [3];
        ent_t ent; out_t got;
        seq = '{S_FETCH, S_FETCH, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b0};
        rst = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(seq[i], rdy[i], rst[i]);
            @(negedge clk);
            got = obs(); ent = sb.pop_front(); checks++;
            if ((got & ent.m) !== (ent.e & ent.m)) begin
                errors++;
                $display("FAIL reset step %0d: got %h expected %h mask %h", i, got, ent.e, ent.m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        logic [3:0] seq [6];
        logic       rdy [6];
        ent_t ent; out_t got;
        opcode = c_op_lw;
        seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(seq[i], rdy[i], 1'b0);
            @(negedge clk);
            got = obs(); ent = sb.pop_front(); checks++;
            if ((got & ent.m) !== (ent.e & ent.m)) begin
                errors++;
                $display("FAIL lw step %0d: got %h expected %h mask %h", i, got, ent.e, ent.m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [3:0] seq [4];
        logic       rdy [4];
        ent_t ent; out_t got;
        opcode = c_op_beq;
        seq = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            for (int i = 0; i < 4; i++) begin
                drive(seq[i], rdy[i], 1'b0);
                @(negedge clk);
                got = obs(); ent = sb.pop_front(); checks++;
                if ((got & ent.m) !== (ent.e & ent.m)) begin
                    errors++;
                    $display("FAIL beq zero=%0d step %0d: got %h expected %h mask %h",
                             z, i, got, ent.e, ent.m);
                end
                @(posedge clk); #1;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_sw_stall();
        logic [3:0] seq [8];
        logic       rdy [8];
        ent_t ent; out_t got;
        opcode = c_op_sw;
        seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_MEMWR, S_MEMWR, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(seq[i], rdy[i], 1'b0);
            @(negedge clk);
            got = obs(); ent = sb.pop_front(); checks++;
            if ((got & ent.m) !== (ent.e & ent.m)) begin
                errors++;
                $display("FAIL sw_stall step %0d: got %h expected %h mask %h", i, got, ent.e, ent.m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_fetch_stall();
        logic [3:0] seq [5];
        logic       rdy [5];
        ent_t ent; out_t got;
        opcode = c_op_j;
        seq = '{S_FETCH, S_FETCH, S_DECODE, S_JUMP, S_FETCH};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i], rdy[i], 1'b0);
            @(negedge clk);
            got = obs(); ent = sb.pop_front(); checks++;
            if ((got & ent.m) !== (ent.e & ent.m)) begin
                errors++;
                $display("FAIL jump step %0d: got %h expected %h mask %h", i, got, ent.e, ent.m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [3:0] seq [5];
        logic       rdy [5];
        logic [5:0] fns [6];
        ent_t ent; out_t got;
        opcode = c_op_rtype;
        seq = '{S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        fns = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b100000, 6'b000111};
        for (int f = 0; f < 6; f++) begin
            funct = fns[f];
            for (int i = 0; i < 5; i++) begin
                drive(seq[i], rdy[i], 1'b0);
                @(negedge clk);
                got = obs(); ent = sb.pop_front(); checks++;
                if ((got & ent.m) !== (ent.e & ent.m)) begin
                    errors++;
                    $display("FAIL rtype funct=%b step %0d: got %h expected %h mask %h",
                             fns[f], i, got, ent.e, ent.m);
                end
                if (seq[i] == S_EXECUTE) begin
                    checks++;
                    if (d2_alu_control !== {2'b00, ent.e.aluc}) begin
                        errors++;
                        $display("FAIL alu_w5 funct=%b: got %b expected %b",
                                 fns[f], d2_alu_control, {2'b00, ent.e.aluc});
                    end
                end
                @(posedge clk); #1;
            end
        end
        funct = 6'b0;
    endtask

    task automatic test_illegal(input logic [5:0] op);
        logic [3:0] seq [3];
        logic       rdy [3];
        ent_t ent; out_t got;
        opcode = op;
        seq = '{S_FETCH, S_DECODE, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(seq[i], rdy[i], 1'b0);
            @(negedge clk);
            got = obs(); ent = sb.pop_front(); checks++;
            if ((got & ent.m) !== (ent.e & ent.m)) begin
                errors++;
                $display("FAIL illegal op=%b step %0d: got %h expected %h mask %h",
                         op, i, got, ent.e, ent.m);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef MC_ADDI_EN
    task automatic test_addi();
        logic [3:0] seq [5];
        logic       rdy [5];
        ent_t ent; out_t got;
        opcode = c_op_addi;
        seq = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i], rdy[i], 1'b0);
            @(negedge clk);
            got = obs(); ent = sb.pop_front(); checks++;
            if ((got & ent.m) !== (ent.e & ent.m)) begin
                errors++;
                $display("FAIL addi step %0d: got %h expected %h mask %h", i, got, ent.e, ent.m);
            end
            @(posedge clk); #1;
        end
    endtask
`else
    task automatic test_addi();
        test_illegal(c_op_addi);
    endtask
`endif

    task automatic test_reset_in_stall();
        logic [3:0] seq [7];
        logic       rdy [7];
        logic       rst [7];
        ent_t ent; out_t got;
        opcode = c_op_lw;
        seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_FETCH, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(seq[i], rdy[i], rst[i]);
            @(negedge clk);
            got = obs(); ent = sb.pop_front(); checks++;
            if ((got & ent.m) !== (ent.e & ent.m)) begin
                errors++;
                $display("FAIL reset_stall step %0d: got %h expected %h mask %h", i, got, ent.e, ent.m);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_branch();
        test_sw_stall();
        test_jump_fetch_stall();
        test_rtype();
        test_addi();
        test_illegal(6'b111111);
        test_reset_in_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
